// File: rtl/serial_paralelo_rx_param_if.sv
// Serial receiver bundle: the serial line in, and the parallel word path out.
// data_in is driven by the line side; everything else is driven by the receiver.
// Flow semantics: no back-pressure exists. valid_out qualifies sp_out for the WIDTH
// cycles following a word boundary; the consumer samples sp_out when word_stb
// pulses together with valid_out. A word is never repeated or held off.
interface serial_paralelo_rx_param_if #(
    parameter int WIDTH = 8
) ();
    logic             data_in;
    logic [WIDTH-1:0] sp_out;
    logic             valid_out;
    logic             active;
    logic             word_stb;
    logic             comma_det;
    logic [1:0]       state_dbg;

    // line / consumer side
    modport master (
        output data_in,
        input  sp_out, valid_out, active, word_stb, comma_det, state_dbg
    );

    // receiver side
    modport slave (
        input  data_in,
        output sp_out, valid_out, active, word_stb, comma_det, state_dbg
    );
endinterface

// File: rtl/serial_paralelo_rx_param.sv
// Parametrised serial-to-parallel receiver. Hunts for COMMA at any bit offset,
// aligns the word boundary to it, locks after LOCK_COUNT aligned commas and then
// delivers non-comma words on sp_out. An optional watchdog drops lock after
// MAX_GAP consecutive non-comma words.
module serial_paralelo_rx_param #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
    parameter int               LOCK_COUNT = 4,
    parameter int               MAX_GAP    = 0,
    parameter int               GAP_W      = 8
) (
    input  logic                       clk_32f,
    input  logic                       reset_L,
    serial_paralelo_rx_param_if.slave  rx
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int CC_W  = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [CC_W-1:0]  LOCK_V    = CC_W'(LOCK_COUNT);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(MAX_GAP);
    localparam logic [GAP_W-1:0] GAP_SAT   = '1;

    // Debug encoding exported on state_dbg: HUNT=0, SYNC=1, ACTIVE=2.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t           state,       state_n;
    logic [WIDTH-1:0] sr,          sr_n;
    logic [CNT_W-1:0] bit_cnt,     bit_cnt_n;
    logic [CC_W-1:0]  comma_cnt,   comma_cnt_n;
    logic [GAP_W-1:0] gap_cnt,     gap_cnt_n;
    logic [WIDTH-1:0] sp_q,        sp_n;
    logic             valid_q,     valid_n;
    logic             active_q,    active_n;
    logic             word_stb_q,  word_stb_n;
    logic             comma_det_q, comma_det_n;

    logic [WIDTH-1:0] nxt;
    logic             is_comma;
    logic             at_boundary;
    logic [CC_W-1:0]  comma_inc;
    logic [GAP_W-1:0] gap_inc;

    // Next-state and output decode; every target gets its hold/default value first.
    always_comb begin
        nxt         = {sr[WIDTH-2:0], rx.data_in};
        is_comma    = (nxt == COMMA);
        at_boundary = (bit_cnt == LAST_BIT);
        comma_inc   = (comma_cnt >= LOCK_V) ? comma_cnt : comma_cnt + CC_W'(1);
        gap_inc     = (gap_cnt == GAP_SAT) ? gap_cnt : gap_cnt + GAP_W'(1);

        state_n     = state;
        sr_n        = nxt;
        bit_cnt_n   = at_boundary ? '0 : bit_cnt + CNT_W'(1);
        comma_cnt_n = comma_cnt;
        gap_cnt_n   = gap_cnt;
        sp_n        = sp_q;
        valid_n     = valid_q;
        active_n    = active_q;
        word_stb_n  = 1'b0;
        comma_det_n = 1'b0;

        case (state)
            HUNT: begin
                // Bit offset is unknown here, so the comparison runs every cycle.
                gap_cnt_n = '0;
                valid_n   = 1'b0;
                active_n  = 1'b0;
                if (is_comma) begin
                    // This edge becomes the word boundary.
                    bit_cnt_n   = '0;
                    comma_cnt_n = CC_W'(1);
                    comma_det_n = 1'b1;
                    if (LOCK_COUNT == 1) begin
                        state_n  = ACTIVE;
                        active_n = 1'b1;
                    end else begin
                        state_n = SYNC;
                    end
                end
            end

            SYNC: begin
                gap_cnt_n = '0;
                if (at_boundary) begin
                    word_stb_n = 1'b1;
                    if (is_comma) begin
                        comma_cnt_n = comma_inc;
                        comma_det_n = 1'b1;
                        if (comma_inc >= LOCK_V) begin
                            state_n  = ACTIVE;
                            active_n = 1'b1;
                        end
                    end else begin
                        // Alignment was a false hit; start the hunt over.
                        comma_cnt_n = '0;
                        state_n     = HUNT;
                    end
                end
            end

            ACTIVE: begin
                if (at_boundary) begin
                    word_stb_n = 1'b1;
                    if (is_comma) begin
                        valid_n     = 1'b0;
                        comma_det_n = 1'b1;
                        gap_cnt_n   = '0;
                    end else begin
                        sp_n      = nxt;
                        valid_n   = 1'b1;
                        gap_cnt_n = gap_inc;
                        if ((MAX_GAP != 0) && (gap_inc == GAP_LIMIT)) begin
                            // Too long without a comma: assume alignment is lost.
                            state_n     = HUNT;
                            active_n    = 1'b0;
                            valid_n     = 1'b0;
                            comma_cnt_n = '0;
                        end
                    end
                end
            end

            default: begin
                state_n  = HUNT;
                valid_n  = 1'b0;
                active_n = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately, even mid-word.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state       <= HUNT;
            sr          <= '0;
            bit_cnt     <= '0;
            comma_cnt   <= '0;
            gap_cnt     <= '0;
            sp_q        <= '0;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
            word_stb_q  <= 1'b0;
            comma_det_q <= 1'b0;
        end else begin
            state       <= state_n;
            sr          <= sr_n;
            bit_cnt     <= bit_cnt_n;
            comma_cnt   <= comma_cnt_n;
            gap_cnt     <= gap_cnt_n;
            sp_q        <= sp_n;
            valid_q     <= valid_n;
            active_q    <= active_n;
            word_stb_q  <= word_stb_n;
            comma_det_q <= comma_det_n;
        end
    end

    assign rx.sp_out    = sp_q;
    assign rx.valid_out = valid_q;
    assign rx.active    = active_q;
    assign rx.word_stb  = word_stb_q;
    assign rx.comma_det = comma_det_q;
    assign rx.state_dbg = state;

endmodule
